// File: rtl/lock_timer_sequencer_if.sv
// lock_timer_sequencer_if: Avalon-MM link between the sequencer and the
// lock's interval-timer slave (16-bit data, word addressed).
// master: address/write/read/writedata out; readdata/readdatavalid/waitrequest in
// slave:  the mirror of master
interface lock_timer_sequencer_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [15:0]       avm_writedata;
  logic [15:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/lock_timer_sequencer.sv
// lock_timer_sequencer: programs the interval timer for N ticks of a given
// period, acknowledges each timeout, then stops the timer.
// Ports: clk, reset_n (async, active-low); cmd_valid/cmd_ready/cmd_period/
// cmd_count/cmd_abort command side; busy/done/aborted/elapsed status;
// avm (timer bus, master modport); timer_irq (level).
// Macro LOCK_TIMER_SEQ_POLL_EN: poll status instead of using timer_irq.
module lock_timer_sequencer #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_period,
  input  logic [CNT_W-1:0]      cmd_count,
  input  logic                  cmd_abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      elapsed,
  lock_timer_sequencer_if.master avm,
  input  logic                  timer_irq
);

  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PL   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_PH   = ADDR_W'(3);
  localparam logic [15:0] CTL_STOP = 16'h0008;
`ifdef LOCK_TIMER_SEQ_POLL_EN
  localparam logic [15:0] CTL_START = 16'h0006;
`else
  localparam logic [15:0] CTL_START = 16'h0007;
`endif

  typedef enum logic [3:0] {
    IDLE, WR_STOP, WR_CLR, WR_PL, WR_PH, WR_START,
    WAIT_TO, WR_ACK, GUARD, WR_HALT, DONE, ABORTED,
    RD_WAIT, RD_GAP
  } state_t;

  state_t            state;
  state_t            wr_next;
  logic [31:0]       p_q;
  logic [CNT_W-1:0]  remaining;
  logic              abort_q;
  logic              wr_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [1:0]        gap_q;
  logic              abort_live;
  logic              abort_now;

  assign avm.avm_address   = addr_q;
  assign avm.avm_write     = wr_q;
  assign avm.avm_read      = rd_q;
  assign avm.avm_writedata = data_q;

  // Aborts are only honoured before the halt write has started.
  assign abort_live = !(state inside {IDLE, WR_HALT, DONE, ABORTED});
  assign abort_now  = abort_live && (abort_q || cmd_abort);

`ifdef LOCK_TIMER_SEQ_POLL_EN
  logic poll_unused;
  assign poll_unused = ^{avm.avm_readdata[15:1], timer_irq};
`else
  logic poll_unused;
  assign poll_unused = ^{avm.avm_readdata, avm.avm_readdatavalid};
`endif

  always_comb begin
    wr_addr = A_STAT;
    wr_data = '0;
    wr_next = IDLE;
    unique case (state)
      WR_STOP:  begin wr_addr = A_CTRL; wr_data = CTL_STOP;   wr_next = WR_CLR;   end
      WR_CLR:   begin                                          wr_next = WR_PL;    end
      WR_PL:    begin wr_addr = A_PL;   wr_data = p_q[15:0];  wr_next = WR_PH;    end
      WR_PH:    begin wr_addr = A_PH;   wr_data = p_q[31:16]; wr_next = WR_START; end
      WR_START: begin wr_addr = A_CTRL; wr_data = CTL_START;  wr_next = WAIT_TO;  end
      WR_ACK:   begin                                          wr_next = GUARD;    end
      WR_HALT:  begin wr_addr = A_CTRL; wr_data = CTL_STOP;   wr_next = DONE;     end
      default:  begin                                                              end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      p_q       <= '0;
      remaining <= '0;
      abort_q   <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      gap_q     <= '0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      aborted   <= 1'b0;
      elapsed   <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort_now) abort_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            p_q       <= (cmd_period < 32'd2) ? 32'd1 : cmd_period - 32'd1;
            remaining <= cmd_count;
            elapsed   <= '0;
            abort_q   <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= (cmd_count == '0) ? DONE : WR_STOP;
          end
        end
        DONE, ABORTED: begin
          done      <= (state == DONE);
          aborted   <= (state == ABORTED);
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
`ifdef LOCK_TIMER_SEQ_POLL_EN
        WAIT_TO: begin
          if (rd_q) begin
            if (!avm.avm_waitrequest) begin
              rd_q  <= 1'b0;
              state <= RD_WAIT;
            end
          end else if (abort_now) begin
            state <= WR_HALT;
          end else begin
            rd_q   <= 1'b1;
            addr_q <= A_STAT;
          end
        end
        RD_WAIT: begin
          if (avm.avm_readdatavalid) begin
            gap_q <= 2'd3;
            state <= avm.avm_readdata[0] ? WR_ACK : RD_GAP;
          end
        end
        // Four idle cycles, then the next read goes out directly.
        RD_GAP: begin
          if (gap_q != 2'd0) begin
            gap_q <= gap_q - 2'd1;
          end else if (abort_now) begin
            state <= WR_HALT;
          end else begin
            rd_q   <= 1'b1;
            addr_q <= A_STAT;
            state  <= WAIT_TO;
          end
        end
`else
        // Abort beats a same-cycle timeout: that tick is not counted.
        WAIT_TO: begin
          if (abort_now)      state <= WR_HALT;
          else if (timer_irq) state <= WR_ACK;
        end
`endif
        GUARD: state <= abort_now ? WR_HALT : WAIT_TO;
        // Each write has an idle cycle before its request, so START
        // never follows the PH write back-to-back.
        WR_STOP, WR_CLR, WR_PL, WR_PH, WR_START, WR_ACK, WR_HALT: begin
          if (!wr_q) begin
            if (abort_now) begin
              state <= WR_HALT;
            end else begin
              wr_q   <= 1'b1;
              addr_q <= wr_addr;
              data_q <= wr_data;
            end
          end else if (!avm.avm_waitrequest) begin
            wr_q <= 1'b0;
            if (state == WR_HALT) begin
              state <= abort_q ? ABORTED : DONE;
            end else if (state == WR_ACK) begin
              elapsed   <= (&elapsed) ? elapsed : elapsed + CNT_W'(1);
              remaining <= remaining - CNT_W'(1);
              state     <= (remaining == CNT_W'(1) || abort_now) ? WR_HALT : GUARD;
            end else begin
              state <= abort_now ? WR_HALT : wr_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lock_timer_sequencer.md
Name: lock_timer_sequencer

Overview:
- Avalon-MM master that programs and services the lock's interval-timer slave (16-bit data, 3-bit word address, registered readdata).
- Accepts a command of period and tick count, then configures the timer in continuous interrupt mode.
- Acknowledges each timeout and stops the timer after the requested number of ticks.
- Used by lockout and auto-relock logic so that the Nios II does not have to service the timer.

Parameters:
- ADDR_W, 3, master word-address width.
- CNT_W, 16, width of the tick count and elapsed counter.

Ports:
- clk  in  1  clock (already decided).
- reset_n  in  1  asynchronous, active-low reset (already decided).
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_period  in  32  tick length in clk cycles.
- cmd_count  in  CNT_W  number of ticks to run.
- cmd_abort  in  1  level; requests early stop.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort completion.
- elapsed  out  CNT_W  ticks acknowledged since the last accept.
- avm_address  out  ADDR_W  word address.
- avm_write  out  1  write request.
- avm_read  out  1  read request (used only with the optional feature).
- avm_writedata  out  16  write data.
- avm_readdata  in  16  read data.
- avm_readdatavalid  in  1  read data valid.
- avm_waitrequest  in  1  stall.
- timer_irq  in  1  timer interrupt, level-sensitive.

Behaviour:
- Timer register map:
  - 0 status: write clears TO; read bit0=TO, bit1=RUN.
  - 1 control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2 period_l.
  - 3 period_h.
- Reset values: avm_write=0, avm_read=0, avm_address=0, avm_writedata=0, busy=0, done=0, aborted=0, elapsed=0, state=IDLE, cmd_ready=1.
- Bus rules:
  - Address, data and request are held stable while avm_waitrequest=1.
  - A transfer completes on the first cycle with request=1 and waitrequest=0.
  - The next state is entered on the following edge.
  - At most one transaction is outstanding.
- Accept, at most one per cycle:
  - Latch P = max(cmd_period, 2) - 1. The timer counts P..0, so one tick = max(cmd_period, 2) cycles.
  - Latch remaining = cmd_count and clear elapsed.
  - If cmd_count == 0: go to DONE with no bus activity.
- FSM write sequence after accept:
  - WR_STOP: addr1, data 0x0008.
  - WR_CLR: addr0, data 0.
  - WR_PL: addr2, data P[15:0].
  - WR_PH: addr3, data P[31:16].
  - WR_START: addr1, data 0x0007 (ITO|CONT|START).
  - Then WAIT_TO.
- The START write is always at least one cycle after the PH write completes. This lets the timer's reload-on-period-write take effect first.
- WAIT_TO: timer_irq=1 → WR_ACK.
- WR_ACK: addr0, data 0. On completion:
  - elapsed += 1, remaining -= 1.
  - remaining becomes 0 → WR_HALT.
  - Otherwise → GUARD (1 cycle, irq ignored) → WAIT_TO.
- WR_HALT: addr1, data 0x0008. Then DONE, or ABORTED if the abort flag is set.
- DONE and ABORTED each last 1 cycle, pulse their output, then return to IDLE.
- Abort:
  - cmd_abort sampled high in any busy state sets an abort flag.
  - The in-flight transfer completes first; a request is never dropped under waitrequest.
  - Then → WR_HALT → ABORTED. elapsed keeps its value.
  - Abort during WR_HALT, DONE or ABORTED is ignored.
  - Abort and timer_irq in the same WAIT_TO cycle: abort wins; the tick is not counted.
- elapsed saturates at all-ones.
- cmd_valid while busy: ignored; there is no queue.
- Asynchronous reset mid-sequence:
  - All outputs return to reset values immediately.
  - The timer is not stopped by this block; the next command's WR_STOP/WR_CLR recovers it.

Optional Feature:
- Macro: LOCK_TIMER_SEQ_POLL_EN.
- Defined: timer_irq is ignored and control data uses ITO=0 (START 0x0006).
  - WAIT_TO issues a read of addr0.
  - Completion of the read is followed by a wait for avm_readdatavalid.
  - readdata bit0=1 → WR_ACK; otherwise re-read after a 4-cycle gap.
  - Abort is checked only between reads.
- Undefined: irq-driven as above; avm_read is constant 0.

Test Plan:
- No waitrequest; cmd_period=5, cmd_count=3:
  - Required write order: (1,0x8), (0,0), (2,4), (3,0), (1,0x7).
  - Timer model raises irq every 5 cycles; 3 acks to addr0, then (1,0x8).
  - done pulses once; elapsed=3; busy falls the cycle after DONE.
- cmd_period=0x00012345, cmd_count=1, with waitrequest held 3 cycles on each transfer:
  - Writes are held stable while stalled.
  - PL=0x2344, PH=0x0001.
  - done after a single tick.
- cmd_count=0 → done pulses 2 cycles after accept; no avm_write; elapsed=0.
- Abort while the PL write is stalled:
  - The PL write completes, then (1,0x8).
  - aborted pulses; done stays 0; no PH or START write is issued.
- Abort and irq in the same cycle after 2 ticks of cmd_count=5 → elapsed=2; aborted pulse; no ack write for that tick.
- LOCK_TIMER_SEQ_POLL_EN defined; status reads return 0,0,1:
  - Exactly 3 reads spaced by the 4-cycle gap, then the ack write.
  - START data is 0x0006.
